// File: rtl/l15_arbiter.sv
// l15_arbiter: shares the single L1.5 transducer request/response channel
// between the instruction-fetch requester and the load/store requester.
// Waits for the L1.5 wake-up interrupt, grants one outstanding transaction
// at a time, and routes the matching response back to the owner.
// Optional feature macro: L15ARB_FAIR_EN (fetch anti-starvation counter).
module l15_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        nrst,

    input  logic        if_val,
    input  logic [4:0]  if_rqtype,
    input  logic [2:0]  if_size,
    input  logic [31:0] if_address,
    input  logic [63:0] if_data,
    output logic        if_header_ack,
    output logic        if_resp_val,

    input  logic        mem_val,
    input  logic [4:0]  mem_rqtype,
    input  logic [2:0]  mem_size,
    input  logic [31:0] mem_address,
    input  logic [63:0] mem_data,
    output logic        mem_header_ack,
    output logic        mem_resp_val,

    output logic        transducer_l15_val,
    output logic [4:0]  transducer_l15_rqtype,
    output logic [2:0]  transducer_l15_size,
    output logic [31:0] transducer_l15_address,
    output logic [63:0] transducer_l15_data,

    input  logic        l15_transducer_header_ack,
    input  logic        l15_transducer_ack,
    input  logic        l15_transducer_val,
    input  logic [3:0]  l15_transducer_returntype,
    output logic        transducer_l15_req_ack,

    output logic        arb_eqmem,
    output logic        awake
);

    localparam logic [1:0] SLEEP    = 2'd0;
    localparam logic [1:0] IDLE     = 2'd1;
    localparam logic [1:0] WAIT_ACK = 2'd2;
    localparam logic [1:0] RESP     = 2'd3;

    localparam logic [3:0] RT_LOAD_RET  = 4'b0000;
    localparam logic [3:0] RT_IFILL_RET = 4'b0001;
    localparam logic [3:0] RT_ST_ACK    = 4'b0100;
    localparam logic [3:0] RT_WAKEUP    = 4'b0111;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       owner;        // 0 = fetch, 1 = memory
    logic       force_if;     // fetch must win this arbitration
    logic       pick_mem;     // memory is the current winner in IDLE
    logic       any_req;
    logic       grant;
    logic       routable;
    logic       wake_seen;
    logic       src_en;       // drive request fields at all
    logic       src_mem;      // request fields come from the memory side

`ifdef L15ARB_FAIR_EN
    localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;

    assign force_if = if_val && (starve_cnt == CW'(STARVE_LIMIT));
`else
    assign force_if = 1'b0;
`endif

    assign any_req   = if_val || mem_val;
    assign pick_mem  = mem_val && !force_if;
    assign wake_seen = l15_transducer_val && (l15_transducer_returntype == RT_WAKEUP);
    assign routable  = (l15_transducer_returntype == RT_LOAD_RET)  ||
                       (l15_transducer_returntype == RT_IFILL_RET) ||
                       (l15_transducer_returntype == RT_ST_ACK);

    // Every response is consumed in the cycle it appears; non-routable ones are simply dropped.
    assign transducer_l15_req_ack = l15_transducer_val && nrst;

    assign arb_eqmem = owner && ((state == WAIT_ACK) || (state == RESP));

    // Arbitration, header-ack routing, response routing and next-state selection.
    always_comb begin
        state_nxt          = state;
        transducer_l15_val = 1'b0;
        if_header_ack      = 1'b0;
        mem_header_ack     = 1'b0;
        if_resp_val        = 1'b0;
        mem_resp_val       = 1'b0;
        grant              = 1'b0;
        src_en             = 1'b0;
        src_mem            = 1'b0;

        case (state)
            SLEEP: begin
                if (wake_seen) begin
                    state_nxt = IDLE;
                end
            end

            IDLE: begin
                transducer_l15_val = any_req;
                src_en             = any_req;
                src_mem            = pick_mem;
                if (pick_mem) begin
                    mem_header_ack = l15_transducer_header_ack;
                end else if (if_val) begin
                    if_header_ack  = l15_transducer_header_ack;
                end
                grant = any_req && l15_transducer_header_ack;
                if (grant) begin
                    state_nxt = l15_transducer_ack ? RESP : WAIT_ACK;
                end
            end

            WAIT_ACK: begin
                src_en  = 1'b1;
                src_mem = owner;
                if (l15_transducer_ack) begin
                    state_nxt = RESP;
                end
            end

            RESP: begin
                src_en  = 1'b1;
                src_mem = owner;
                if (l15_transducer_val && routable) begin
                    if (owner) begin
                        mem_resp_val = 1'b1;
                    end else begin
                        if_resp_val  = 1'b1;
                    end
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = SLEEP;
            end
        endcase
    end

    // Request field mux: the winner while arbitrating, the owner while the transaction is open.
    always_comb begin
        transducer_l15_rqtype  = '0;
        transducer_l15_size    = '0;
        transducer_l15_address = '0;
        transducer_l15_data    = '0;
        if (src_en) begin
            if (src_mem) begin
                transducer_l15_rqtype  = mem_rqtype;
                transducer_l15_size    = mem_size;
                transducer_l15_address = mem_address;
                transducer_l15_data    = mem_data;
            end else begin
                transducer_l15_rqtype  = if_rqtype;
                transducer_l15_size    = if_size;
                transducer_l15_address = if_address;
                transducer_l15_data    = if_data;
            end
        end
    end

    // State, owner and wake-up flag registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= SLEEP;
            owner <= 1'b0;
            awake <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner <= pick_mem;
            end
            if ((state == SLEEP) && wake_seen) begin
                awake <= 1'b1;
            end
        end
    end

`ifdef L15ARB_FAIR_EN
    // Count memory grants taken while fetch waits; any fetch grant clears it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (!pick_mem) begin
                starve_cnt <= '0;
            end else if (if_val && (starve_cnt != CW'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/l15_arbiter.md
# l15_arbiter

Shares the single OpenPiton L1.5 transducer request/response channel between the instruction-fetch requester and the load/store (memory) requester. It absorbs the L1.5 wake-up interrupt, grants one outstanding transaction at a time, and routes the matching response back to the owner. It sits between the frontend/memory stages and the `transducer_l15_*` / `l15_transducer_*` pins. It also drives `arb_eqmem` so the frontend can stall while a memory transaction owns the channel.

## Interface
- `STARVE_LIMIT`, 4: consecutive memory grants allowed while fetch is pending before fetch is forced (used only with `L15ARB_FAIR_EN`).
- `clk` in 1: clock, single domain.
- `nrst` in 1: reset, asynchronous, active-low.
- `if_val` in 1: fetch request valid.
- `if_rqtype` in 5: fetch request type.
- `if_size` in 3: fetch request size.
- `if_address` in 32: fetch request address.
- `if_data` in 64: fetch request data.
- `if_header_ack` out 1: fetch header accepted.
- `if_resp_val` out 1: one-cycle response pulse to fetch.
- `mem_val`, `mem_rqtype`, `mem_size`, `mem_address`, `mem_data` in 1/5/3/32/64: memory request, same meaning as the fetch fields.
- `mem_header_ack` out 1: memory header accepted.
- `mem_resp_val` out 1: one-cycle response pulse to memory.
- `transducer_l15_val` out 1: request valid to L1.5.
- `transducer_l15_rqtype` out 5, `transducer_l15_size` out 3, `transducer_l15_address` out 32, `transducer_l15_data` out 64: muxed request fields.
- `l15_transducer_header_ack` in 1: L1.5 header ack.
- `l15_transducer_ack` in 1: L1.5 request ack.
- `l15_transducer_val` in 1: L1.5 response valid.
- `l15_transducer_returntype` in 4: L1.5 response type.
- `transducer_l15_req_ack` out 1: response consumed.
- `arb_eqmem` out 1: memory owns the channel (states WAIT_ACK/RESP).
- `awake` out 1: wake-up interrupt seen.
- Requesters read `l15_transducer_data_0/1` directly; the arbiter does not pass them through.

## Operation
- States are SLEEP, IDLE, WAIT_ACK and RESP. Registers: `owner` (0 = fetch, 1 = memory) and `starve_cnt`.
- **SLEEP:**
  - `transducer_l15_val` = 0.
  - Any `l15_transducer_val` is acked (`transducer_l15_req_ack` = 1).
  - If `l15_transducer_returntype` = 4'b0111, go to IDLE and set `awake`.
- **IDLE:**
  - Winner is `mem` if `mem_val`, else `if` if `if_val`. Under the fairness rule, `if` wins when `if_val` and `starve_cnt` = `STARVE_LIMIT`.
  - Request fields and `transducer_l15_val` = the winner's. With no requester, all fields are 0.
  - `l15_transducer_header_ack` is routed only to the winner's `*_header_ack`.
  - On header_ack && val: latch `owner`. Go to RESP if `l15_transducer_ack` in the same cycle, else WAIT_ACK.
- **WAIT_ACK:**
  - `transducer_l15_val` = 0; fields are held from the latched owner.
  - On `l15_transducer_ack`, go to RESP.
- **RESP:**
  - Routable returntypes are 4'b0000 LOAD_RET, 4'b0001 IFILL_RET and 4'b0100 ST_ACK.
  - On `l15_transducer_val` with a routable type: pulse the owner's `*_resp_val`, assert `transducer_l15_req_ack`, go to IDLE.
- **Non-routable responses** (invalidations, interrupts, other types) in any state other than SLEEP: acked the same cycle and dropped. No state change, no `*_resp_val`.
- **`starve_cnt`:**
  - +1 on each memory grant while `if_val` = 1, saturating at `STARVE_LIMIT`.
  - Cleared on any fetch grant.
- **Reset:** `nrst` low at any time forces SLEEP immediately and aborts any in-flight transaction. A new 4'b0111 is required before further grants.

## Timing
- Reset values:
  - state = SLEEP, `owner` = 0, `starve_cnt` = 0.
  - All outputs 0, including `awake`, `arb_eqmem`, `transducer_l15_val`, both `*_header_ack`, both `*_resp_val` and all request fields.
- All grant, ack and response routing is combinational within the cycle. State and `owner` update at the next `posedge clk`.
- Exactly one transaction is outstanding at a time.
- Earliest back-to-back: response in cycle N, next request valid in cycle N+1 (IDLE).
- Simultaneous `if_val` and `mem_val` in IDLE: memory wins, except under the forced-fetch rule.
- Winner `val` dropping before header_ack: no grant; the arbiter re-arbitrates each cycle.
- `l15_transducer_ack` and a routable response in the same RESP cycle: the response is honored (ack is ignored outside WAIT_ACK/IDLE).

## Configuration
- `L15ARB_FAIR_EN` defined: the `starve_cnt` fairness rule is active and `STARVE_LIMIT` applies.
- `L15ARB_FAIR_EN` undefined: strict memory priority. `starve_cnt` is absent and `STARVE_LIMIT` is ignored.

## Test plan
- **Wake-up:** after reset, `if_val` = 1 gives `transducer_l15_val` = 0. `l15_transducer_val` with returntype 4'b0111 gives `req_ack` = 1; the next cycle `awake` = 1 and `transducer_l15_val` = 1 with `address` = `if_address` (0x40000000).
- **Fetch with split ack:** header_ack in cycle N, ack in N+2, then IFILL_RET in N+4. Expect WAIT_ACK for N+1..N+2 with val = 0, `if_resp_val` = 1 and `req_ack` = 1 only in N+4, `mem_resp_val` = 0.
- **Contention:** `if_val` and `mem_val` both set with `mem_address` = 0x80001000. Expect grant to memory, `mem_header_ack` = 1, `if_header_ack` = 0, and `arb_eqmem` = 1 until the ST_ACK response.
- **Stray response:** while in RESP, an invalidation (4'b0011) arrives. Expect it acked, no `*_resp_val`, state stays RESP; the following LOAD_RET is delivered to the owner.
- **Fairness** (with `L15ARB_FAIR_EN`, `STARVE_LIMIT` = 4): `mem_val` and `if_val` held high continuously. Expect 4 memory grants, then 1 fetch grant; without the macro, fetch is never granted.
- **Reset mid-transaction:** `nrst` pulled low in WAIT_ACK. Expect all outputs 0 immediately and SLEEP after release.
